instruction_fetch_controller: RTL and testbench

Sequences the combinational instruction memory. Owns the program counter, drives the memory fetch address, and registers each fetched instruction with its PC into a valid/ready output stage feeding decode. Handles branch redirect, halt/resume, debug PC writes and misaligned-target faults. Suppresses capture while the debug port owns the memory address mux.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/instruction_fetch_controller.sv | 134 +++++++++++++
 tb/tb_instruction_fetch_controller.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch controller.
package fetch_pkg;

    localparam int unsigned FETCH_CNT_W = 16;

    typedef enum logic [1:0] {
        FETCH_RUN    = 2'd0,
        FETCH_HALTED = 2'd1,
        FETCH_FAULT  = 2'd2
    } fetch_state_e;

endpackage : fetch_pkg

// File: rtl/instruction_fetch_controller.sv
// Instruction fetch controller: owns the PC, drives the combinational
// instruction memory and registers each fetched instruction into a
// valid/ready stage for decode. Handles redirect, halt/resume, debug PC
// writes and sticky misaligned-target faults.
module instruction_fetch_controller
    import fetch_pkg::*;
#(
    parameter int unsigned          I_ADDR_W   = 12,
    parameter int unsigned          INST_W     = 16,
    parameter int unsigned          INST_BYTES = (INST_W + 7) / 8,
    parameter logic [I_ADDR_W-1:0]  RESET_PC   = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic [I_ADDR_W-1:0]     imem_addr,
    input  logic [INST_W-1:0]       imem_instruction,
    input  logic                    debug_enable,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [INST_W-1:0]       out_instr,
    output logic [I_ADDR_W-1:0]     out_pc,
    input  logic                    redirect_valid,
    input  logic [I_ADDR_W-1:0]     redirect_target,
    input  logic                    halt_req,
    input  logic                    resume,
    input  logic                    dbg_pc_we,
    input  logic [I_ADDR_W-1:0]     dbg_pc_wdata,
    output logic                    halted,
    output logic                    fault,
    output logic [FETCH_CNT_W-1:0]  fetch_count
);

    fetch_state_e               state, state_n;
    logic [I_ADDR_W-1:0]        pc, pc_n;
    logic                       out_valid_n;
    logic [INST_W-1:0]          out_instr_n;
    logic [I_ADDR_W-1:0]        out_pc_n;
    logic                       fault_n;
    logic [FETCH_CNT_W-1:0]     fetch_count_n;

    logic                       transfer_c;
    logic                       target_aligned_c;
    logic                       can_accept_c;

    // Fetch address is the PC itself; halted reflects a fully drained halt.
    assign imem_addr = pc;
    assign halted    = (state == FETCH_HALTED) && !out_valid;

    // Handshake and alignment helpers.
    always_comb begin
        transfer_c       = out_valid && out_ready;
        can_accept_c     = !out_valid || out_ready;
        target_aligned_c = ((32'(redirect_target) % INST_BYTES) == 32'd0);
    end

    // Next-state, PC and output-stage logic.
    always_comb begin
        state_n       = state;
        pc_n          = pc;
        out_instr_n   = out_instr;
        out_pc_n      = out_pc;
        fault_n       = fault;
        out_valid_n   = out_valid && !transfer_c;
        fetch_count_n = fetch_count + FETCH_CNT_W'(transfer_c);

        unique case (state)
            FETCH_RUN: begin
                if (redirect_valid) begin
                    out_valid_n = 1'b0;
                    if (target_aligned_c) begin
                        pc_n = redirect_target;
                    end else begin
                        state_n = FETCH_FAULT;
                        fault_n = 1'b1;
                    end
                end else if (halt_req) begin
                    state_n = FETCH_HALTED;
                end else if (!debug_enable && can_accept_c) begin
                    out_instr_n = imem_instruction;
                    out_pc_n    = pc;
                    out_valid_n = 1'b1;
                    pc_n        = pc + I_ADDR_W'(INST_BYTES);
                end
            end
            FETCH_HALTED: begin
                if (redirect_valid) begin
                    out_valid_n = 1'b0;
                    if (target_aligned_c) begin
                        pc_n = redirect_target;
                    end else begin
                        state_n = FETCH_FAULT;
                        fault_n = 1'b1;
                    end
                end else begin
                    if (dbg_pc_we) begin
                        pc_n = dbg_pc_wdata;
                    end
                    if (resume && !halt_req) begin
                        state_n = FETCH_RUN;
                    end
                end
            end
            FETCH_FAULT: begin
                state_n = FETCH_FAULT;
            end
            default: begin
                state_n = FETCH_FAULT;
                fault_n = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH_RUN;
            pc          <= RESET_PC;
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_pc      <= '0;
            fault       <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            out_valid   <= out_valid_n;
            out_instr   <= out_instr_n;
            out_pc      <= out_pc_n;
            fault       <= fault_n;
            fetch_count <= fetch_count_n;
        end
    end

endmodule : instruction_fetch_controller

// File: tb/tb_instruction_fetch_controller.sv
// Self-checking bench for instruction_fetch_controller: directed scenarios
// followed by randomized traffic, all compared against a cycle reference model.
module tb_instruction_fetch_controller;

    localparam int unsigned AW = 12;
    localparam int unsigned IW = 16;
    localparam int unsigned DEPTH = 4096;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   imem_addr;
    logic [IW-1:0]   imem_instruction;
    logic            debug_enable;
    logic            out_valid;
    logic            out_ready;
    logic [IW-1:0]   out_instr;
    logic [AW-1:0]   out_pc;
    logic            redirect_valid;
    logic [AW-1:0]   redirect_target;
    logic            halt_req;
    logic            resume;
    logic            dbg_pc_we;
    logic [AW-1:0]   dbg_pc_wdata;
    logic            halted;
    logic            fault;
    logic [15:0]     fetch_count;

    logic [IW-1:0]   mem [DEPTH];

    int total = 0;
    int bad   = 0;

    // Reference model state (mode: 0 running, 1 halted, 2 faulted).
    int              m_mode;
    logic [AW-1:0]   m_pc;
    logic            m_ov;
    logic [IW-1:0]   m_oi;
    logic [AW-1:0]   m_opc;
    logic            m_fault;
    logic [15:0]     m_count;

    always #5 clk = ~clk;

    assign imem_instruction = mem[imem_addr];

    instruction_fetch_controller dut (
        .clk              (clk),
        .rst              (rst),
        .imem_addr        (imem_addr),
        .imem_instruction (imem_instruction),
        .debug_enable     (debug_enable),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instr        (out_instr),
        .out_pc           (out_pc),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .halt_req         (halt_req),
        .resume           (resume),
        .dbg_pc_we        (dbg_pc_we),
        .dbg_pc_wdata     (dbg_pc_wdata),
        .halted           (halted),
        .fault            (fault),
        .fetch_count      (fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        logic xfer;
        if (rst) begin
            m_mode = 0; m_pc = '0; m_ov = 1'b0; m_oi = '0; m_opc = '0;
            m_fault = 1'b0; m_count = '0;
            return;
        end
        xfer    = m_ov && out_ready;
        m_count = m_count + 16'(xfer);
        if (m_mode == 2) begin
            m_ov = 1'b0;
            return;
        end
        if (xfer) m_ov = 1'b0;
        if (redirect_valid) begin
            m_ov = 1'b0;
            if (redirect_target % 2 != 0) begin
                m_mode  = 2;
                m_fault = 1'b1;
            end else begin
                m_pc = redirect_target;
            end
        end else if (m_mode == 0) begin
            if (halt_req) begin
                m_mode = 1;
            end else if (!debug_enable && (!xfer ? !m_ov : 1'b1)) begin
                m_oi  = mem[m_pc];
                m_opc = m_pc;
                m_ov  = 1'b1;
                m_pc  = AW'((int'(m_pc) + 2) % DEPTH);
            end
        end else begin
            if (dbg_pc_we) m_pc = dbg_pc_wdata;
            if (resume && !halt_req) m_mode = 0;
        end
    endtask

    task automatic compare_all();
        check("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
            check("out_pc", 32'(out_pc), 32'(m_opc));
            check("out_instr", 32'(out_instr), 32'(m_oi));
        end
        check("imem_addr", 32'(imem_addr), 32'(m_pc));
        check("halted", 32'(halted), 32'((m_mode == 1) && !m_ov));
        check("fault", 32'(fault), 32'(m_fault));
        check("fetch_count", 32'(fetch_count), 32'(m_count));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle();
        rst = 1'b0; debug_enable = 1'b0; out_ready = 1'b1;
        redirect_valid = 1'b0; redirect_target = '0;
        halt_req = 1'b0; resume = 1'b0; dbg_pc_we = 1'b0; dbg_pc_wdata = '0;
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = 16'($urandom);
        idle();
        m_mode = 0; m_pc = '0; m_ov = 1'b0; m_oi = '0; m_opc = '0;
        m_fault = 1'b0; m_count = '0;

        // Reset and sequential fetch.
        rst = 1'b1;
        step(); step();
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_addr", 32'(imem_addr), 32'h000);
        rst = 1'b0;
        step();
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_pc", 32'(out_pc), 32'h000);
        step(); step();
        check("third_pc", 32'(out_pc), 32'h004);
        check("third_count", 32'(fetch_count), 32'd2);

        // Backpressure holds everything.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", 32'(out_pc), 32'h004);
            check("stall_addr", 32'(imem_addr), 32'h006);
        end
        out_ready = 1'b1;
        step();
        check("after_stall_pc", 32'(out_pc), 32'h006);

        // Aligned redirect flushes.
        redirect_valid = 1'b1; redirect_target = 12'h100;
        step();
        check("redir_flush", 32'(out_valid), 32'd0);
        check("redir_addr", 32'(imem_addr), 32'h100);
        redirect_valid = 1'b0;
        step();
        check("redir_pc", 32'(out_pc), 32'h100);

        // PC wrap-around.
        redirect_valid = 1'b1; redirect_target = 12'hFFE;
        step();
        redirect_valid = 1'b0;
        step();
        check("wrap_hi", 32'(out_pc), 32'hFFE);
        step();
        check("wrap_lo", 32'(out_pc), 32'h000);

        // Misaligned redirect faults until reset.
        redirect_valid = 1'b1; redirect_target = 12'h101;
        step();
        check("fault_set", 32'(fault), 32'd1);
        redirect_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("fault_noval", 32'(out_valid), 32'd0);
        end
        rst = 1'b1;
        step();
        check("fault_clr", 32'(fault), 32'd0);
        check("fault_rst_pc", 32'(imem_addr), 32'h000);
        rst = 1'b0;

        // Halt while stalled, debug PC write, resume.
        step(); step();
        out_ready = 1'b0;
        step();
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        check("halt_held", 32'(out_valid), 32'd1);
        step();
        out_ready = 1'b1;
        step();
        check("halted_drained", 32'(halted), 32'd1);
        debug_enable = 1'b1;
        step(); step();
        check("dbg_en_nocap", 32'(out_valid), 32'd0);
        debug_enable = 1'b0;
        dbg_pc_we = 1'b1; dbg_pc_wdata = 12'h040;
        step();
        dbg_pc_we = 1'b0;
        resume = 1'b1;
        step();
        resume = 1'b0;
        step();
        check("resume_pc", 32'(out_pc), 32'h040);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            rst             = ($urandom_range(0, 199) == 0) || (m_mode == 2 && $urandom_range(0, 15) == 0);
            out_ready       = ($urandom_range(0, 3) != 0);
            debug_enable    = ($urandom_range(0, 6) == 0);
            redirect_valid  = ($urandom_range(0, 11) == 0);
            redirect_target = 12'($urandom);
            if ($urandom_range(0, 7) != 0) redirect_target[0] = 1'b0;
            halt_req        = ($urandom_range(0, 19) == 0);
            resume          = ($urandom_range(0, 7) == 0);
            dbg_pc_we       = ($urandom_range(0, 9) == 0);
            dbg_pc_wdata    = 12'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_instruction_fetch_controller
